// File: rtl/window_frame_sequencer.sv
// ---------------------------------------------------------------------------
// window_frame_sequencer
//
// Frame-level controller in front of the Hanning window datapath. It gates
// the raw audio stream into frames of exactly FRAME_LEN samples. It drives
// the coefficient address so that every frame starts at coefficient 0, and
// it opens a frame only once the downstream FFT reports ready. Windowed
// output is tagged with first/last markers delayed by WIN_LATENCY to match
// the window pipeline.
//
// Ports:
//   clk_in            - system clock
//   rst_n_in          - asynchronous active-low reset; release is synchronised
//   start_in          - one-cycle request to begin framing (IDLE only)
//   abort_in          - one-cycle request to kill the current frame
//   cont_in           - level; re-arm automatically after a completed frame
//   fft_ready_in      - level; checked only when a frame is opened
//   audio_sample_in   - raw signed sample
//   audio_valid_in    - raw sample strobe
//   win_sample_out    - sample to the window datapath
//   win_valid_out     - window datapath strobe
//   win_addr_out      - coefficient index of the forwarded sample
//   tag_first_out     - aligned with first windowed sample of a frame
//   tag_last_out      - aligned with last windowed sample of a frame
//   tag_valid_out     - aligned with every windowed sample
//   busy_out          - high in every state except IDLE
//   frame_done_out    - pulse when the last tag leaves the pipeline
//   frame_aborted_out - pulse on an accepted abort
//   dropped_count_out - saturating count of samples seen outside FILL
//
// Build option:
//   WINSEQ_DROP_COUNT_EN - when defined, the 16-bit drop counter is built;
//                          otherwise dropped_count_out is tied to zero.
// ---------------------------------------------------------------------------
module window_frame_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int FRAME_LEN   = 4096,
    parameter int WIN_LATENCY = 3
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         start_in,
    input  logic                         abort_in,
    input  logic                         cont_in,
    input  logic                         fft_ready_in,
    input  logic [DATA_WIDTH-1:0]        audio_sample_in,
    input  logic                         audio_valid_in,
    output logic [DATA_WIDTH-1:0]        win_sample_out,
    output logic                         win_valid_out,
    output logic [$clog2(FRAME_LEN)-1:0] win_addr_out,
    output logic                         tag_first_out,
    output logic                         tag_last_out,
    output logic                         tag_valid_out,
    output logic                         busy_out,
    output logic                         frame_done_out,
    output logic                         frame_aborted_out,
    output logic [15:0]                  dropped_count_out
);

    localparam int ADDR_W  = $clog2(FRAME_LEN);
    localparam int DRAIN_W = (WIN_LATENCY > 1) ? $clog2(WIN_LATENCY) : 1;
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(FRAME_LEN - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(WIN_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_READY,
        ST_FILL,
        ST_DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic                 run_q;
    logic [ADDR_W-1:0]    cnt_q;
    logic [DRAIN_W-1:0]   drain_q;
    // Per stage: [2] valid, [1] first, [0] last
    logic [WIN_LATENCY-1:0][2:0] tag_pipe_q;

    logic abort_hit;
    logic open_frame;
    logic fwd_en;
    logic drain_end;

    // Single release flop: logic stays parked for the first rising edge after
    // rst_n_in deasserts, so the second edge is the first active one.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
        end else if (run_q) begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (abort_in && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                // A simultaneous abort suppresses the start even in IDLE.
                ST_IDLE:       if (start_in && !abort_in) state_d = ST_WAIT_READY;
                ST_WAIT_READY: if (fft_ready_in)          state_d = ST_FILL;
                ST_FILL:       if (audio_valid_in && (cnt_q == LAST_ADDR)) state_d = ST_DRAIN;
                ST_DRAIN:      if (drain_q == DRAIN_LAST)
                                   state_d = cont_in ? ST_WAIT_READY : ST_IDLE;
                default:       state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        busy_out   = (state_q != ST_IDLE);
        abort_hit  = abort_in && (state_q != ST_IDLE);
        open_frame = (state_q == ST_WAIT_READY) && fft_ready_in && !abort_in;
        fwd_en     = (state_q == ST_FILL) && audio_valid_in && !abort_in;
        drain_end  = (state_q == ST_DRAIN) && (drain_q == DRAIN_LAST) && !abort_in;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            win_sample_out    <= '0;
            win_valid_out     <= 1'b0;
            win_addr_out      <= '0;
            frame_done_out    <= 1'b0;
            frame_aborted_out <= 1'b0;
            cnt_q             <= '0;
            drain_q           <= '0;
            tag_pipe_q        <= '0;
        end else if (run_q) begin
            win_valid_out     <= fwd_en;
            frame_done_out    <= drain_end;
            frame_aborted_out <= abort_hit;

            if (fwd_en) begin
                win_sample_out <= audio_sample_in;
                win_addr_out   <= cnt_q;
            end

            if (abort_hit || open_frame) begin
                cnt_q <= '0;
            end else if (fwd_en) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if ((state_q == ST_DRAIN) && !abort_in) begin
                drain_q <= drain_q + 1'b1;
            end else begin
                drain_q <= '0;
            end

            // Tags trail win_valid_out by WIN_LATENCY cycles; an abort flushes
            // every stage so nothing from the killed frame emerges later.
            if (abort_hit) begin
                tag_pipe_q <= '0;
            end else begin
                for (int unsigned i = WIN_LATENCY - 1; i > 0; i--) begin
                    tag_pipe_q[i] <= tag_pipe_q[i-1];
                end
                tag_pipe_q[0] <= {win_valid_out,
                                  win_valid_out && (win_addr_out == '0),
                                  win_valid_out && (win_addr_out == LAST_ADDR)};
            end
        end
    end

    assign tag_valid_out = tag_pipe_q[WIN_LATENCY-1][2];
    assign tag_first_out = tag_pipe_q[WIN_LATENCY-1][1];
    assign tag_last_out  = tag_pipe_q[WIN_LATENCY-1][0];

`ifdef WINSEQ_DROP_COUNT_EN
    logic [15:0] drop_q;
    logic        drop_en;

    assign drop_en = audio_valid_in && (state_q != ST_FILL);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            drop_q <= '0;
        end else if (run_q && drop_en && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign dropped_count_out = drop_q;
`else
    assign dropped_count_out = '0;
`endif

endmodule
